epd_param: RTL

- Parametrised Ethernet packet detector. Parses a byte stream framed by `control` into preamble/SFD, destination MAC, source MAC, type/length and payload.
- Flags each field as valid, checks payload size against configurable bounds and counts good and dropped frames.
- Adds optional destination filtering, saturating counters and a per-frame done/error report.
- Sits at the receive front end in place of the fixed 4-bit-counter detector.

---
 rtl/epd_pkg.sv | 32 +++
 rtl/epd_frame_counter.sv | 35 +++
 rtl/epd_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/epd_pkg.sv
// Shared types and framing constants for the Ethernet packet detector.
package epd_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      PRE,
      DST,
      SRC,
      TL,
      PAY,
      DRAIN
   } state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [10:0] PRE_LEN  = 11'd8;
   localparam logic [10:0] ADDR_LEN = 11'd6;
   localparam logic [10:0] TL_LEN   = 11'd2;

   localparam logic [15:0] TYPE_MIN = 16'h0600;
   localparam logic [15:0] LEN_MAX  = 16'd1500;

   localparam logic [47:0] BROADCAST = 48'hFFFF_FFFF_FFFF;

   // 1501..1535 is neither a legal length nor a legal EtherType.
   function automatic logic tl_field_ok(input logic [15:0] v);
      return (v <= LEN_MAX) || (v >= TYPE_MIN);
   endfunction

endpackage

// File: rtl/epd_frame_counter.sv
// Frame counter with enable; saturates at all-ones or wraps to zero.
module epd_frame_counter #(
   parameter int CNT_W    = 4,
   parameter int SATURATE = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if ((SATURATE != 0) && (cnt_q == '1)) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/epd_param.sv
// Parametrised Ethernet packet detector: parses preamble, addresses, type/length
// and payload, flags each field and counts good and dropped frames.
module epd_param
   import epd_pkg::*;
#(
   parameter int          CNT_W         = 4,
   parameter int          MIN_PAYLOAD   = 46,
   parameter int          MAX_PAYLOAD   = 1500,
   parameter int          DST_FILTER_EN = 0,
   parameter logic [47:0] MAC_ADDR      = 48'h0000_0000_0000,
   parameter int          SATURATE      = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       data,
   input  logic             control,
   output logic             preamble_valid,
   output logic             dst_addr_valid,
   output logic             src_addr_valid,
   output logic             type_length_valid,
   output logic             packet_size_valid,
   output logic             frame_done,
   output logic             frame_good,
   output logic [CNT_W-1:0] valid_packet_counter,
   output logic [CNT_W-1:0] dropped_packet_counter
);

   localparam logic [10:0] PAY_CAP = 11'(MAX_PAYLOAD + 1);
   localparam logic [15:0] MIN_P16 = 16'(MIN_PAYLOAD);
   localparam logic [15:0] MAX_P16 = 16'(MAX_PAYLOAD);

   state_e      state_q, state_d;
   logic [10:0] idx_q, idx_d;
   logic [47:0] shift_q, shift_d;
   logic [15:0] tl_q, tl_d;
   logic        pre_q, pre_d;
   logic        dst_q, dst_d;
   logic        src_q, src_d;
   logic        tlv_q, tlv_d;
   logic        size_q, size_d;
   logic        done_q, done_d;
   logic        good_q, good_d;

   logic [47:0] shift_nx;
   logic [15:0] cnt16;
   logic [15:0] len_req;
   logic        size_ok;
   logic        inc_good, inc_drop;

   assign shift_nx = {shift_q[39:0], data};

   // idx_q doubles as the payload byte count while in PAY.
   always_comb begin
      cnt16   = {5'b0, idx_q};
      len_req = (tl_q > MIN_P16) ? tl_q : MIN_P16;
      if (tl_q >= TYPE_MIN) begin
         size_ok = (cnt16 >= MIN_P16) && (cnt16 <= MAX_P16);
      end else begin
         size_ok = (cnt16 == len_req);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tl_d    = tl_q;
      pre_d   = pre_q;
      dst_d   = dst_q;
      src_d   = src_q;
      tlv_d   = tlv_q;
      size_d  = size_q;
      done_d  = 1'b0;
      good_d  = 1'b0;

      unique case (state_q)
         WAIT_IDLE: begin
            if (!control) state_d = IDLE;
         end
         IDLE: begin
            if (control) begin
               pre_d  = 1'b0;
               dst_d  = 1'b0;
               src_d  = 1'b0;
               tlv_d  = 1'b0;
               size_d = 1'b0;
               idx_d  = 11'd1;
               state_d = (data == PREAMBLE_BYTE) ? PRE : DRAIN;
            end
         end
         default: begin
            if (!control) begin
               // End of frame: only a frame that reached PAY can be good.
               state_d = IDLE;
               done_d  = 1'b1;
               if (state_q == PAY) size_d = size_ok;
               good_d  = (state_q == PAY) && pre_q && dst_q && src_q && tlv_q && size_ok;
            end else begin
               unique case (state_q)
                  PRE: begin
                     if (idx_q == PRE_LEN - 11'd1) begin
                        if (data == SFD_BYTE) begin
                           pre_d   = 1'b1;
                           idx_d   = '0;
                           state_d = DST;
                        end else begin
                           state_d = DRAIN;
                        end
                     end else if (data == PREAMBLE_BYTE) begin
                        idx_d = idx_q + 11'd1;
                     end else begin
                        state_d = DRAIN;
                     end
                  end
                  DST: begin
                     shift_d = shift_nx;
                     if (idx_q == ADDR_LEN - 11'd1) begin
                        if (DST_FILTER_EN != 0) begin
                           dst_d = (shift_nx == MAC_ADDR) || (shift_nx == BROADCAST);
                        end else begin
                           dst_d = 1'b1;
                        end
                        idx_d   = '0;
                        state_d = SRC;
                     end else begin
                        idx_d = idx_q + 11'd1;
                     end
                  end
                  SRC: begin
                     shift_d = shift_nx;
                     if (idx_q == ADDR_LEN - 11'd1) begin
                        src_d   = ~shift_nx[40];
                        idx_d   = '0;
                        state_d = TL;
                     end else begin
                        idx_d = idx_q + 11'd1;
                     end
                  end
                  TL: begin
                     shift_d = shift_nx;
                     if (idx_q == TL_LEN - 11'd1) begin
                        tl_d    = shift_nx[15:0];
                        tlv_d   = tl_field_ok(shift_nx[15:0]);
                        idx_d   = '0;
                        state_d = PAY;
                     end else begin
                        idx_d = idx_q + 11'd1;
                     end
                  end
                  PAY: begin
                     if (idx_q != PAY_CAP) idx_d = idx_q + 11'd1;
                  end
                  default: begin
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= WAIT_IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         tl_q    <= '0;
         pre_q   <= 1'b0;
         dst_q   <= 1'b0;
         src_q   <= 1'b0;
         tlv_q   <= 1'b0;
         size_q  <= 1'b0;
         done_q  <= 1'b0;
         good_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tl_q    <= tl_d;
         pre_q   <= pre_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         tlv_q   <= tlv_d;
         size_q  <= size_d;
         done_q  <= done_d;
         good_q  <= good_d;
      end
   end

   assign inc_good = good_d;
   assign inc_drop = done_d & ~good_d;

   epd_frame_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
   ) u_good_cnt (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (inc_good),
      .count_o (valid_packet_counter)
   );

   epd_frame_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
   ) u_drop_cnt (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (inc_drop),
      .count_o (dropped_packet_counter)
   );

   assign preamble_valid    = pre_q;
   assign dst_addr_valid    = dst_q;
   assign src_addr_valid    = src_q;
   assign type_length_valid = tlv_q;
   assign packet_size_valid = size_q;
   assign frame_done        = done_q;
   assign frame_good        = good_q;

endmodule
